harmonic_synth_n: RTL and testbench
===================================

HARMONIC_SYNTH_N -- requirements
Module: harmonic_synth_n

Interface
- REQ-001 SHALL: parameter NUM_HARM, default 4, number of harmonics summed (legal 1..8).
- REQ-002 SHALL: parameter PHASE_W, default 20, phase accumulator width.
- REQ-003 SHALL: parameter ROM_AW, default 10, sine ROM address width (ROM_AW <= PHASE_W).
- REQ-004 SHALL: parameter SAMPLE_W, default 16, signed sample width.
- REQ-005 SHALL: parameter GAIN_W, default 4, unsigned per-harmonic gain width.
- REQ-006 SHALL: parameter OUT_SHIFT, default 2, extra arithmetic right shift applied to the mix.
- REQ-007 SHALL: clk  in  1  sole clock, all logic on rising edge.
- REQ-008 SHALL: reset  in  1  synchronous, active-high reset.
- REQ-009 SHALL: play_enable  in  1  requests are accepted only while high.
- REQ-010 SHALL: generate_next_sample  in  1  one-cycle sample request.
- REQ-011 SHALL: step_size  in  PHASE_W  fundamental phase increment per sample.
- REQ-012 SHALL: gains  in  NUM_HARM*GAIN_W  gain of harmonic k in bits [k*GAIN_W +: GAIN_W]; k=0 is the fundamental.
- REQ-013 SHALL: note_done  in  1  forces sample_out to zero.
- REQ-014 SHALL: rom_addr  out  ROM_AW  full-wave sine ROM address.
- REQ-015 SHALL: rom_data  in  SAMPLE_W  signed ROM word, valid one cycle after rom_addr.
- REQ-016 SHALL: busy  out  1  high from request acceptance until sample_ready.
- REQ-017 SHALL: sample_out  out  SAMPLE_W  signed mixed sample, held between updates.
- REQ-018 SHALL: sample_ready  out  1  one-cycle pulse when sample_out updates.

Function
- REQ-019 SHALL: one phase accumulator per harmonic, modulo 2^PHASE_W.
- REQ-020 SHALL: FSM states IDLE, ISSUE, DRAIN, OUTPUT.
- REQ-021 SHALL: in IDLE, generate_next_sample & play_enable accepts a request, latches step_size, gains and note_done, and moves to ISSUE.
- REQ-022 SHALL: ISSUE lasts NUM_HARM cycles; in cycle k, phase_k += (k+1)*step_size, and rom_addr = new phase_k[PHASE_W-1 -: ROM_AW].
- REQ-023 SHALL: form the multiple (k+1)*step_size by running addition of the latched step, with no multiplier.
- REQ-024 SHALL: accumulate rom_data * gain_k (signed x unsigned) one cycle after each address, into an accumulator of SAMPLE_W+GAIN_W+clog2(NUM_HARM)+1 bits cleared at acceptance.
- REQ-025 SHALL: DRAIN lasts 1 cycle and takes the last product.
- REQ-026 SHALL: OUTPUT lasts 1 cycle; mix = acc >>> (GAIN_W+OUT_SHIFT), reduced to SAMPLE_W per REQ-034/035.
- REQ-027 SHALL: OUTPUT registers the reduced mix, or zero if the latched note_done is set, into sample_out, then returns to IDLE.
- REQ-028 SHALL: sample_ready pulses exactly NUM_HARM+2 cycles after the accepting cycle, and busy drops in that same cycle.
- REQ-029 SHALL: requests while busy, or with play_enable low, are ignored and not queued; phases are left unchanged.
- REQ-030 SHALL: play_enable falling mid-computation does not abort it; the sample completes normally.
- REQ-031 SHALL: rom_addr holds its last value outside ISSUE.

Reset
- REQ-032 SHALL: reset forces FSM to IDLE and sets all phases, the accumulator, sample_out, rom_addr, busy and sample_ready to 0.
- REQ-033 SHALL: reset mid-computation discards the sample, and no sample_ready follows.

Configuration
- REQ-034 SHALL: with HARMONIC_SYNTH_SATURATE_EN defined, a mix outside the signed SAMPLE_W range clamps to +2^(SAMPLE_W-1)-1 or -2^(SAMPLE_W-1).
- REQ-035 SHALL: without HARMONIC_SYNTH_SATURATE_EN, the mix is truncated to its low SAMPLE_W bits (two's-complement wrap).

Verification (defaults, ROM bench model with 1-cycle latency)
- REQ-036 SHALL: step_size=0x00400, one request -> rom_addr sequence 1,2,3,4 on consecutive cycles; sample_ready pulses 6 cycles after acceptance.
- REQ-037 SHALL: rom_data constant 1000, gains all 15 -> sample_out=937 (60000>>>6).
- REQ-038 SHALL: rom_data 32767, gains all 15, OUT_SHIFT=0 -> sample_out=32767 with macro defined, -8196 without.
- REQ-039 SHALL: step_size=0x80000, two requests -> harmonic 2 (k=1) address 0 both times (phase wraps); fundamental address 512 then 0.
- REQ-040 SHALL: a second request 2 cycles into a computation is ignored (one sample_ready only); reset asserted in cycle 3 -> no sample_ready, sample_out=0, and the next request yields rom_addr sequence 1,2,3,4 again.
- REQ-041 SHALL: note_done=1 at acceptance -> sample_ready pulses and sample_out=0; phases still advance.

Source files
------------

// File: rtl/harmonic_synth_n.sv
// Additive synthesiser: sums NUM_HARM sine harmonics read from a shared ROM, one sample per request.
// Define HARMONIC_SYNTH_SATURATE_EN to clamp the mix instead of wrapping it.
module harmonic_synth_n #(
  parameter int unsigned NUM_HARM  = 4,
  parameter int unsigned PHASE_W   = 20,
  parameter int unsigned ROM_AW    = 10,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned GAIN_W    = 4,
  parameter int unsigned OUT_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_enable,
  input  logic                         generate_next_sample,
  input  logic [PHASE_W-1:0]           step_size,
  input  logic [NUM_HARM*GAIN_W-1:0]   gains,
  input  logic                         note_done,
  output logic [ROM_AW-1:0]            rom_addr,
  input  logic [SAMPLE_W-1:0]          rom_data,
  output logic                         busy,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_ready
);

  localparam int unsigned IdxW  = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int unsigned AccW  = SAMPLE_W + GAIN_W + $clog2(NUM_HARM) + 1;
  localparam int unsigned ProdW = SAMPLE_W + GAIN_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOutput} state_e;

  state_e                       state_q, state_d;
  logic [PHASE_W-1:0]           phase_q [NUM_HARM];
  logic [PHASE_W-1:0]           step_q, mult_q, mult_d, phase_next;
  logic [NUM_HARM*GAIN_W-1:0]   gains_q;
  logic                         done_q;
  logic [IdxW-1:0]              idx_q, idx_d, rd_idx_q;
  logic                         rd_vld_q;
  logic [ROM_AW-1:0]            rom_addr_q;
  logic signed [AccW-1:0]       acc_q, acc_d, mix;
  logic signed [ProdW-1:0]      prod;
  logic [GAIN_W-1:0]            gain_sel;
  logic [SAMPLE_W-1:0]          mix_red, sample_out_q;
  logic                         busy_q, ready_q;
  logic                         accept, last_issue;

  assign accept     = (state_q == StIdle) && generate_next_sample && play_enable;
  // mult_q holds (k+1)*step for the harmonic being issued, built by running addition
  assign phase_next = phase_q[idx_q] + mult_q;
  assign last_issue = (idx_q == IdxW'(NUM_HARM - 1));
  assign rom_addr   = (state_q == StIssue) ? phase_next[PHASE_W-1 -: ROM_AW] : rom_addr_q;

  // ROM word for harmonic rd_idx_q arrives the cycle after its address
  assign gain_sel = gains_q[int'(rd_idx_q)*GAIN_W +: GAIN_W];
  assign prod     = ProdW'($signed(rom_data)) * ProdW'($signed({1'b0, gain_sel}));
  assign mix      = acc_q >>> (GAIN_W + OUT_SHIFT);

`ifdef HARMONIC_SYNTH_SATURATE_EN
  localparam logic signed [AccW-1:0] SatMax = AccW'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  always_comb begin
    mix_red = mix[SAMPLE_W-1:0];
    if (mix > SatMax) begin
      mix_red = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (mix < SatMin) begin
      mix_red = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end
  end
`else
  assign mix_red = mix[SAMPLE_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          idx_d   = '0;
          mult_d  = step_size;
        end
      end
      StIssue: begin
        mult_d = mult_q + step_q;
        idx_d  = idx_q + 1'b1;
        if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain:  state_d = StOutput;
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (accept) begin
      acc_d = '0;
    end else if (rd_vld_q) begin
      acc_d = acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      for (int k = 0; k < int'(NUM_HARM); k++) begin
        phase_q[k] <= '0;
      end
      step_q       <= '0;
      mult_q       <= '0;
      gains_q      <= '0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      rd_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      rom_addr_q   <= '0;
      acc_q        <= '0;
      sample_out_q <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mult_q   <= mult_d;
      acc_q    <= acc_d;
      rd_vld_q <= (state_q == StIssue);
      rd_idx_q <= idx_q;
      ready_q  <= (state_q == StOutput);
      if (accept) begin
        step_q  <= step_size;
        gains_q <= gains;
        done_q  <= note_done;
        busy_q  <= 1'b1;
      end
      if (state_q == StIssue) begin
        phase_q[idx_q] <= phase_next;
        rom_addr_q     <= rom_addr;
      end
      if (state_q == StOutput) begin
        sample_out_q <= done_q ? '0 : mix_red;
        busy_q       <= 1'b0;
      end
    end
  end

  assign busy         = busy_q;
  assign sample_out   = sample_out_q;
  assign sample_ready = ready_q;

endmodule

// File: tb/tb_harmonic_synth_n.sv
// Bench for harmonic_synth_n: default build plus an OUT_SHIFT=0 instance, checked against a
// per-request arithmetic model; honours HARMONIC_SYNTH_SATURATE_EN.
module tb_harmonic_synth_n;

  localparam int NH = 4;

  logic        clk = 1'b0;
  logic        reset, play_enable, gen, note_done;
  logic [19:0] step_size;
  logic [15:0] gains;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] rd_a, rd_b, out_a, out_b;
  logic        busy_a, busy_b, rdy_a, rdy_b;

  logic signed [15:0] rom_mem [1024];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  harmonic_synth_n u_dut_a (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .generate_next_sample (gen),
    .step_size            (step_size),
    .gains                (gains),
    .note_done            (note_done),
    .rom_addr             (addr_a),
    .rom_data             (rd_a),
    .busy                 (busy_a),
    .sample_out           (out_a),
    .sample_ready         (rdy_a)
  );

  harmonic_synth_n #(.OUT_SHIFT(0)) u_dut_b (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .generate_next_sample (gen),
    .step_size            (step_size),
    .gains                (gains),
    .note_done            (note_done),
    .rom_addr             (addr_b),
    .rom_data             (rd_b),
    .busy                 (busy_b),
    .sample_out           (out_b),
    .sample_ready         (rdy_b)
  );

  always @(posedge clk) begin
    rd_a <= rom_mem[addr_a];
    rd_b <= rom_mem[addr_b];
  end

  // Model: a whole sample is computed at acceptance; outputs replayed on the cycle timeline.
  int          m_t;
  int unsigned m_phase [NH];
  int          m_addr [NH];
  logic [9:0]  e_addr;
  logic        e_busy, e_rdy;
  logic [15:0] e_out_a, e_out_b, p_out_a, p_out_b;

  function automatic logic [15:0] reduce(input longint v);
`ifdef HARMONIC_SYNTH_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  task automatic model_update();
    longint sum;
    if (reset) begin
      m_t = -1;
      for (int k = 0; k < NH; k++) m_phase[k] = 0;
      e_addr = '0; e_busy = 1'b0; e_rdy = 1'b0; e_out_a = '0; e_out_b = '0;
    end else begin
      e_rdy = 1'b0;
      if (m_t < 0) begin
        if (gen && play_enable) begin
          sum = 0;
          for (int k = 0; k < NH; k++) begin
            m_phase[k] = (m_phase[k] + (k + 1) * int'(step_size)) & 32'hFFFFF;
            m_addr[k]  = int'(m_phase[k] >> 10);
            sum += longint'(rom_mem[m_addr[k]]) * longint'(gains[k*4 +: 4]);
          end
          p_out_a = note_done ? 16'h0 : reduce(sum >>> 6);
          p_out_b = note_done ? 16'h0 : reduce(sum >>> 4);
          m_t     = 0;
          e_busy  = 1'b1;
          e_addr  = 10'(m_addr[0]);
        end
      end else begin
        m_t++;
        if (m_t < NH) e_addr = 10'(m_addr[m_t]);
        if (m_t == NH + 2) begin
          e_rdy = 1'b1; e_busy = 1'b0; e_out_a = p_out_a; e_out_b = p_out_b; m_t = -1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("addr_a", 32'(addr_a), 32'(e_addr));
    chk("addr_b", 32'(addr_b), 32'(e_addr));
    chk("busy_a", 32'(busy_a), 32'(e_busy));
    chk("busy_b", 32'(busy_b), 32'(e_busy));
    chk("ready_a", 32'(rdy_a), 32'(e_rdy));
    chk("ready_b", 32'(rdy_b), 32'(e_rdy));
    chk("out_a", 32'(out_a), 32'(e_out_a));
    chk("out_b", 32'(out_b), 32'(e_out_b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic req();
    gen = 1'b1;
    cyc();
    gen = 1'b0;
  endtask

  task automatic fill_rom(input int mode, input logic signed [15:0] val);
    for (int i = 0; i < 1024; i++) rom_mem[i] = (mode == 0) ? val : 16'($urandom);
  endtask

  int cnt;

  initial begin
    reset = 1'b1; play_enable = 1'b1; gen = 1'b0; note_done = 1'b0;
    step_size = 20'h0; gains = 16'h0;
    fill_rom(0, 16'sd1000);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);

    // Address sequence, latency and basic mix
    step_size = 20'h00400; gains = 16'hFFFF;
    req();
    chk("seq_addr0", 32'(addr_a), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("seq_addr", 32'(addr_a), 32'(i + 1));
    end
    cyc(); cyc(); cyc();
    chk("lat_ready", 32'(rdy_a), 32'd1);
    chk("mix_937", 32'(out_a), 32'd937);
    chk("mix_3750", 32'(out_b), 32'd3750);

    // Full-scale mix: overflow handling on the OUT_SHIFT=0 instance
    fill_rom(0, 16'sd32767);
    req();
    repeat (6) cyc();
    chk("full_a", 32'(out_a), 32'd30719);
`ifdef HARMONIC_SYNTH_SATURATE_EN
    chk("full_b_sat", 32'(out_b), 32'h7FFF);
`else
    chk("full_b_wrap", 32'(out_b), 32'hDFFC);
`endif

    // Phase wrap at half-cycle step
    reset = 1'b1; cyc(); reset = 1'b0;
    step_size = 20'h80000;
    req();
    chk("wrap1_k0", 32'(addr_a), 32'd512);
    cyc();
    chk("wrap1_k1", 32'(addr_a), 32'd0);
    repeat (5) cyc();
    req();
    chk("wrap2_k0", 32'(addr_a), 32'd0);
    cyc();
    chk("wrap2_k1", 32'(addr_a), 32'd0);
    repeat (5) cyc();

    // Ignored request while busy, then reset mid-computation
    reset = 1'b1; cyc(); reset = 1'b0;
    fill_rom(1, 16'sd0);
    step_size = 20'h00400; gains = 16'($urandom);
    req();
    cyc();
    gen = 1'b1; cyc(); gen = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rdy_a) cnt++;
    end
    chk("one_ready", 32'(cnt), 32'd1);
    req(); cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (rdy_a) cnt++;
    end
    chk("no_ready", 32'(cnt), 32'd0);
    chk("rst_mid_out", 32'(out_a), 32'd0);
    req();
    chk("rerun_addr0", 32'(addr_a), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("rerun_addr", 32'(addr_a), 32'(i + 1));
    end
    repeat (3) cyc();

    // note_done mutes the output but phases still advance
    note_done = 1'b1; gains = 16'hFFFF;
    req();
    note_done = 1'b0;
    repeat (6) cyc();
    chk("done_ready", 32'(rdy_a), 32'd1);
    chk("done_out", 32'(out_a), 32'd0);
    req();
    chk("done_phase", 32'(addr_a), 32'd3);
    repeat (6) cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      play_enable = ($urandom_range(0, 7) != 0);
      gen         = ($urandom_range(0, 2) == 0);
      note_done   = ($urandom_range(0, 7) == 0);
      step_size   = 20'($urandom);
      gains       = 16'($urandom);
      cyc();
    end
    reset = 1'b0; gen = 1'b0;
    repeat (8) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
